// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, word geometry
// and the default reset fetch address.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned FIFO_CNT_W       = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of assembled instructions, entries are {pc, word}.
// Head reads as zero while empty so the fetch outputs idle at zero.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [63:0]           push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [63:0]           head_data,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int unsigned           PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]      LAST  = PTR_W'(DEPTH - 1);
  localparam logic [FIFO_CNT_W-1:0] FULL  = FIFO_CNT_W'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetches 32-bit big-endian instructions one byte at a time from a byte-wide
// instruction memory and buffers them for the decoder.
module inst_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc
);

  localparam logic [FIFO_CNT_W-1:0] DEPTH_C   = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]            LAST_BYTE = 2'(WORD_BYTES - 1);

  fetch_state_t          state, state_nx;
  logic [1:0]            b, b_nx;
  logic [31:0]           fetch_pc, pc_nx;
  logic [31:0]           word_buf, buf_nx;
  logic                  bubble, bubble_nx;
  logic                  push, pop, flush, ack_fire;
  logic [63:0]           push_data, head_data;
  logic [FIFO_CNT_W-1:0] count, occ_after;

  assign imem_req   = (state == FETCH) && !bubble;
  assign imem_addr  = (state == FETCH) ? fetch_pc + {30'd0, b} : '0;
  assign ack_fire   = imem_req && imem_ack;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign {inst_pc, inst_word} = head_data;
  assign push_data  = {fetch_pc, word_buf[31:8], imem_rdata};
  // Occupancy after this edge, so a fetch starts only with a guaranteed free slot
  assign occ_after  = pop ? count : count + FIFO_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      b        <= '0;
      fetch_pc <= RESET_PC;
      word_buf <= '0;
      bubble   <= 1'b0;
    end else begin
      state    <= state_nx;
      b        <= b_nx;
      fetch_pc <= pc_nx;
      word_buf <= buf_nx;
      bubble   <= bubble_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    b_nx      = b;
    pc_nx     = fetch_pc;
    buf_nx    = word_buf;
    bubble_nx = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    if (redirect) begin
      // The bubble keeps the request low for one cycle after the restart
      flush     = 1'b1;
      pc_nx     = {redirect_pc[31:2], 2'b00};
      b_nx      = '0;
      buf_nx    = '0;
      state_nx  = FETCH;
      bubble_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          b_nx     = '0;
          state_nx = (count < DEPTH_C) ? FETCH : HOLD;
        end
        FETCH: begin
          if (ack_fire) begin
            buf_nx[(WORD_BYTES - 1 - int'(b)) * 8 +: 8] = imem_rdata;
            if (b == LAST_BYTE) begin
              push     = 1'b1;
              pc_nx    = fetch_pc + 32'd4;
              b_nx     = '0;
              state_nx = (occ_after < DEPTH_C) ? FETCH : HOLD;
            end else begin
              b_nx = b + 2'd1;
            end
          end
        end
        HOLD: begin
          if (count < DEPTH_C) begin
            state_nx = FETCH;
            b_nx     = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: byte memory model, consumer model predicting the
// in-order pc/word stream, plus directed timing scenarios and random traffic.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;

  inst_fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_word  (inst_word),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned ack_mode;    // 0: ack tied high, 1: random gaps of 0..3 cycles
  int unsigned ready_mode;  // 0: never ready, 1: always ready, 2: random
  int unsigned gap;
  int unsigned ack_cnt;
  int unsigned words_seen;
  logic [31:0] exp_pc;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   mem_byte = 8'h8C;
      32'd1:   mem_byte = 8'h41;
      32'd2:   mem_byte = 8'h00;
      32'd3:   mem_byte = 8'h04;
      default: mem_byte = a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {mem_byte(pc), mem_byte(pc + 32'd1), mem_byte(pc + 32'd2), mem_byte(pc + 32'd3)};
  endfunction

  // One cycle: drive inputs at the falling edge, model memory and consumer.
  task automatic tick(input logic rst_v, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst_n       = rst_v;
    redirect    = redir;
    redirect_pc = rpc;
    if (ack_mode == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_byte(imem_addr);
    end else if (imem_req && gap == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_byte(imem_addr);
      gap        = $urandom_range(3, 0);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
      if (imem_req && gap > 0) gap--;
    end
    if (imem_req && imem_ack) ack_cnt++;
    case (ready_mode)
      0:       inst_ready = 1'b0;
      1:       inst_ready = 1'b1;
      default: inst_ready = 1'($urandom_range(1, 0));
    endcase
    if (hold_v) begin
      check_eq("stall_valid", inst_valid, 1);
      check_eq("stall_pc", inst_pc, hold_pc);
      check_eq("stall_word", inst_word, hold_word);
    end
    hold_v    = rst_v && !redir && inst_valid && !inst_ready;
    hold_pc   = inst_pc;
    hold_word = inst_word;
    if (rst_v && inst_valid && inst_ready) begin
      check_eq("pop_pc", inst_pc, exp_pc);
      check_eq("pop_word", inst_word, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      words_seen++;
    end
    if (!rst_v) exp_pc = RST_PC;
    else if (redir) exp_pc = {rpc[31:2], 2'b00};
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick(1'b1, 1'b0, '0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !inst_valid; i++) run(1);
    check_eq(tag, inst_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    ack_mode = 0; ready_mode = 1; gap = 0; ack_cnt = 0; words_seen = 0;
    exp_pc = RST_PC; hold_v = 1'b0;

    // Reset, first request timing, wrap from FFFF_FFFC, 4-ack word cadence
    repeat (3) tick(1'b0, 1'b0, '0);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_word", inst_word, 0);
    check_eq("rst_pc", inst_pc, 0);
    tick(1'b1, 1'b0, '0);
    check_eq("idle_req", imem_req, 0);
    run(1);
    check_eq("first_req", imem_req, 1);
    check_eq("first_addr", imem_addr, RST_PC);
    run(3);
    check_eq("lat_empty", inst_valid, 0);
    for (int i = 0; i < 8; i++) begin
      run(1);
      check_eq("lat_valid", inst_valid, ((i % 4) == 0));
      if (i == 0) check_eq("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
      if (i == 4) begin
        check_eq("wrap_pc1", inst_pc, 32'h0);
        check_eq("word_8c41", inst_word, 32'h8C41_0004);
      end
    end
    check_eq("acks_tied", ack_cnt, 12);

    // Consumer stalled: two words buffered, then HOLD and resume after a pop
    ready_mode = 0;
    tick(1'b1, 1'b1, 32'h100);
    ack_cnt = 0;
    run(1);
    check_eq("redir_bubble", imem_req, 0);
    check_eq("redir_flush", inst_valid, 0);
    run(1);
    check_eq("redir_req", imem_req, 1);
    check_eq("redir_addr100", imem_addr, 32'h100);
    run(17);
    check_eq("hold_acks", ack_cnt, 8);
    check_eq("hold_req", imem_req, 0);
    check_eq("hold_valid", inst_valid, 1);
    check_eq("hold_head", inst_pc, 32'h100);
    ready_mode = 1;
    run(1);
    ready_mode = 0;
    run(2);
    check_eq("resume_req", imem_req, 1);
    check_eq("resume_addr", imem_addr, 32'h108);

    // Redirect mid-word at b=2 with a concurrent pop
    tick(1'b1, 1'b1, 32'h200);
    run(8);
    check_eq("mid_addr", imem_addr, 32'h206);
    check_eq("mid_valid", inst_valid, 1);
    ready_mode = 1;
    tick(1'b1, 1'b1, 32'h13);
    ready_mode = 0;
    run(1);
    check_eq("mid_flush", inst_valid, 0);
    check_eq("mid_bubble", imem_req, 0);
    run(1);
    check_eq("mid_new_addr", imem_addr, 32'h10);
    ready_mode = 1;
    wait_valid("mid_first_valid");
    check_eq("mid_first_pc", inst_pc, 32'h10);

    // Reset asserted at b=1 with a buffered word and acks in flight
    ready_mode = 0;
    tick(1'b1, 1'b1, 32'h300);
    run(6);
    tick(1'b0, 1'b0, '0);
    check_eq("rst_mid_addr", imem_addr, 32'h305);
    check_eq("rst_mid_valid", inst_valid, 1);
    tick(1'b1, 1'b0, '0);
    check_eq("rst2_req", imem_req, 0);
    check_eq("rst2_addr", imem_addr, 0);
    check_eq("rst2_valid", inst_valid, 0);
    check_eq("rst2_word", inst_word, 0);
    check_eq("rst2_pc", inst_pc, 0);
    run(1);
    check_eq("rst2_first_addr", imem_addr, RST_PC);
    ready_mode = 1;
    wait_valid("rst2_first_valid");
    check_eq("rst2_first_pc", inst_pc, RST_PC);
    run(8);

    // Random ack gaps and random consumer, stream from address 0
    ack_mode = 1;
    ready_mode = 2;
    tick(1'b1, 1'b1, 32'h0);
    words_seen = 0;
    run(600);
    check_eq("random_progress", (words_seen >= 25), 1);

    // Random traffic with occasional redirects to arbitrary addresses
    for (int i = 0; i < 400; i++) tick(1'b1, ($urandom_range(39, 0) == 0), $urandom);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
